lcd_hd44780_responder: RTL and testbench

Synthesizable HD44780-compatible receiver for the 8-bit LCD bus produced by the team's LCD initializer/writer. It samples LCD_DATA/RS/RW on each falling edge of LCD_EN, decodes instructions and data writes, and maintains a 2x16 DDRAM image, address counter and display flags. The bench uses it as a self-checking panel model, and it can mirror screen contents to on-board debug logic.

---
 rtl/lcd_hd44780_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible 8-bit bus receiver: decodes writes, keeps a 2x16 DDRAM image, AC and display flags.
// Define LCD_READBACK_EN to add the LCD_DATA_OUT/LCD_DATA_OE read-back path and RS=1 read AC stepping.
module lcd_hd44780_responder #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int BUSY_CYCLES    = 2000,
    parameter int BUSY_LONG      = 76500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_ON,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] addr_cnt,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       two_line,
    output logic       init_ok,
    output logic       busy,
    output logic       wr_valid,
    output logic       wr_rs,
    output logic [7:0] wr_code,
    output logic       err_timing
`ifdef LCD_READBACK_EN
    ,
    output logic [7:0] LCD_DATA_OUT,
    output logic       LCD_DATA_OE
`endif
);

    localparam logic [1:0] PWR_WAIT = 2'd0;
    localparam logic [1:0] WAIT_FS  = 2'd1;
    localparam logic [1:0] READY    = 2'd2;
    localparam logic [1:0] CLEARING = 2'd3;

    localparam int CNT_MAX = (POWERUP_CYCLES > BUSY_LONG)
                           ? ((POWERUP_CYCLES > BUSY_CYCLES) ? POWERUP_CYCLES : BUSY_CYCLES)
                           : ((BUSY_LONG > BUSY_CYCLES) ? BUSY_LONG : BUSY_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);

    logic          en_q, rs_q, rw_q;
    logic [7:0]    data_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    ac_q, ac_d;
    logic [4:0]    clr_idx_q, clr_idx_d;
    logic [1:0]    fs_cnt_q, fs_cnt_d;
    logic          disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
    logic          entry_inc_q, entry_inc_d, two_line_q, two_line_d, init_ok_q, init_ok_d;
    logic          wr_valid_q, wr_valid_d, wr_rs_q, wr_rs_d, err_q, err_d;
    logic [7:0]    wr_code_q, wr_code_d, rd_data_q;
    logic [7:0]    ddram_q [32];
    logic          mem_we;
    logic [4:0]    mem_waddr;
    logic [7:0]    mem_wdata;
    logic          fall, is_busy;
    logic [5:0]    wmap;

    // AC walks 0x00..0x27 then 0x40..0x67 as one 80-position ring.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] r;
        if (inc) r = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
        else     r = (ac == 7'h40) ? 7'h27 : (ac == 7'h00) ? 7'h67 : ac - 7'd1;
        return r;
    endfunction

    // {visible, line, column}: only the first 16 cells of each line are mirrored.
    function automatic logic [5:0] ddram_map(input logic [6:0] ac);
        return {(ac[6:4] == 3'b000) || (ac[6:4] == 3'b100), ac[6], ac[3:0]};
    endfunction

    assign fall    = en_q && !LCD_EN;
    assign is_busy = (state_q == PWR_WAIT) || (state_q == CLEARING) || (cnt_q != '0);
    assign wmap    = ddram_map(ac_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        ac_d        = ac_q;
        clr_idx_d   = clr_idx_q;
        fs_cnt_d    = fs_cnt_q;
        disp_d      = disp_q;
        cursor_d    = cursor_q;
        blink_d     = blink_q;
        entry_inc_d = entry_inc_q;
        two_line_d  = two_line_q;
        init_ok_d   = init_ok_q;
        err_d       = err_q;
        wr_valid_d  = 1'b0;
        wr_rs_d     = wr_rs_q;
        wr_code_d   = wr_code_q;
        mem_we      = 1'b0;
        mem_waddr   = clr_idx_q;
        mem_wdata   = 8'h20;

        if (state_q == PWR_WAIT) begin
            if (cnt_q <= CW'(1)) begin
                cnt_d   = '0;
                state_d = WAIT_FS;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end

        if (state_q == CLEARING) begin
            mem_we    = 1'b1;
            clr_idx_d = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) state_d = init_ok_q ? READY : WAIT_FS;
        end

        if (fall && !rw_q) begin
            if (is_busy) begin
                err_d = 1'b1;
            end else if (!(state_q == WAIT_FS && rs_q)) begin
                wr_valid_d = 1'b1;
                wr_rs_d    = rs_q;
                wr_code_d  = data_q;
                cnt_d      = CW'(BUSY_CYCLES);
                if (rs_q) begin
                    mem_we    = wmap[5];
                    mem_waddr = wmap[4:0];
                    mem_wdata = data_q;
                    ac_d      = ac_step(ac_q, entry_inc_q);
                end else begin
                    if (state_q == WAIT_FS) begin
                        if (data_q[7:4] == 4'h3) begin
                            fs_cnt_d = fs_cnt_q + 2'd1;
                            if (fs_cnt_q == 2'd2) begin
                                fs_cnt_d  = 2'd0;
                                state_d   = READY;
                                init_ok_d = 1'b1;
                            end
                        end else begin
                            fs_cnt_d = 2'd0;
                        end
                    end
                    casez (data_q)
                        8'b1???????: ac_d = data_q[6:0];
                        8'b01??????: ;
                        8'b001?????: two_line_d = data_q[3];
                        8'b0001????: if (!data_q[3]) ac_d = ac_step(ac_q, data_q[2]);
                        8'b00001???: begin
                            disp_d   = data_q[2] & LCD_ON;
                            cursor_d = data_q[1];
                            blink_d  = data_q[0];
                        end
                        8'b000001??: entry_inc_d = data_q[1];
                        8'b0000001?: begin
                            ac_d  = 7'h00;
                            cnt_d = CW'(BUSY_LONG);
                        end
                        8'b00000001: begin
                            ac_d        = 7'h00;
                            entry_inc_d = 1'b1;
                            clr_idx_d   = 5'd0;
                            state_d     = CLEARING;
                            cnt_d       = CW'(BUSY_LONG);
                        end
                        default: ;
                    endcase
                end
            end
        end
`ifdef LCD_READBACK_EN
        else if (fall && rs_q && !is_busy) begin
            ac_d = ac_step(ac_q, entry_inc_q);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            data_q      <= 8'h00;
            state_q     <= PWR_WAIT;
            cnt_q       <= CW'(POWERUP_CYCLES);
            ac_q        <= 7'h00;
            clr_idx_q   <= 5'd0;
            fs_cnt_q    <= 2'd0;
            disp_q      <= 1'b0;
            cursor_q    <= 1'b0;
            blink_q     <= 1'b0;
            entry_inc_q <= 1'b1;
            two_line_q  <= 1'b0;
            init_ok_q   <= 1'b0;
            err_q       <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_rs_q     <= 1'b0;
            wr_code_q   <= 8'h00;
            rd_data_q   <= 8'h00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            en_q        <= LCD_EN;
            rs_q        <= LCD_RS;
            rw_q        <= LCD_RW;
            data_q      <= LCD_DATA;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ac_q        <= ac_d;
            clr_idx_q   <= clr_idx_d;
            fs_cnt_q    <= fs_cnt_d;
            disp_q      <= disp_d;
            cursor_q    <= cursor_d;
            blink_q     <= blink_d;
            entry_inc_q <= entry_inc_d;
            two_line_q  <= two_line_d;
            init_ok_q   <= init_ok_d;
            err_q       <= err_d;
            wr_valid_q  <= wr_valid_d;
            wr_rs_q     <= wr_rs_d;
            wr_code_q   <= wr_code_d;
            rd_data_q   <= ddram_q[rd_addr];
        end
    end

    // NOTE: the DDRAM array has no reset; its contents survive reset like the real panel's.
    always_ff @(posedge clk) begin
        if (mem_we) ddram_q[mem_waddr] <= mem_wdata;
    end

`ifdef LCD_READBACK_EN
    logic [5:0] rb_map;
    assign rb_map = ddram_map(ac_q);
    always_comb begin
        LCD_DATA_OE  = LCD_RW & LCD_EN;
        LCD_DATA_OUT = LCD_RS ? (rb_map[5] ? ddram_q[rb_map[4:0]] : 8'h00) : {is_busy, ac_q};
    end
`endif

    assign rd_data    = rd_data_q;
    assign addr_cnt   = ac_q;
    assign disp_on    = disp_q;
    assign cursor_on  = cursor_q;
    assign blink_on   = blink_q;
    assign entry_inc  = entry_inc_q;
    assign two_line   = two_line_q;
    assign init_ok    = init_ok_q;
    assign busy       = is_busy;
    assign wr_valid   = wr_valid_q;
    assign wr_rs      = wr_rs_q;
    assign wr_code    = wr_code_q;
    assign err_timing = err_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Scoreboard bench for lcd_hd44780_responder: a panel-level model predicts each accepted write.
module tb_lcd_hd44780_responder;

    localparam int PC = 100;
    localparam int BC = 20;
    localparam int BL = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] LCD_DATA;
    logic       LCD_EN, LCD_RS, LCD_RW, LCD_ON;
    logic [4:0] rd_addr;
    logic [7:0] rd_data, wr_code;
    logic [6:0] addr_cnt;
    logic       disp_on, cursor_on, blink_on, entry_inc, two_line, init_ok;
    logic       busy, wr_valid, wr_rs, err_timing;
`ifdef LCD_READBACK_EN
    logic [7:0] LCD_DATA_OUT;
    logic       LCD_DATA_OE;
`endif

    always #5 clk = ~clk;

    lcd_hd44780_responder #(.POWERUP_CYCLES(PC), .BUSY_CYCLES(BC), .BUSY_LONG(BL)) dut (
        .clk(clk), .rst(rst), .LCD_DATA(LCD_DATA), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_ON(LCD_ON), .rd_addr(rd_addr), .rd_data(rd_data),
        .addr_cnt(addr_cnt), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_inc(entry_inc), .two_line(two_line), .init_ok(init_ok), .busy(busy),
        .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_code(wr_code), .err_timing(err_timing)
`ifdef LCD_READBACK_EN
        , .LCD_DATA_OUT(LCD_DATA_OUT), .LCD_DATA_OE(LCD_DATA_OE)
`endif
    );

    typedef struct packed {
        logic       rs;
        logic [7:0] code;
        logic [6:0] ac;
        logic       disp, cur, blink, inc, two, init;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_wr  = 0;

    // Panel model: AC as a position on the 80-cell ring, DDRAM as a 32-entry array.
    logic [6:0] m_ac;
    logic [7:0] m_mem [32];
    bit         m_disp, m_cur, m_blink, m_inc, m_two, m_init, m_err;
    int         m_fs, m_phase;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] m_step(input logic [6:0] ac, input bit inc);
        int a, p;
        a = int'(ac);
        if (a < 40) p = a;
        else if (a >= 64 && a < 104) p = a - 24;
        else return inc ? ac + 7'd1 : ac - 7'd1;
        p = inc ? (p + 1) % 80 : (p + 79) % 80;
        return (p < 40) ? 7'(p) : 7'(p + 24);
    endfunction

    function automatic int m_index(input logic [6:0] ac);
        int a;
        a = int'(ac);
        if (a < 16) return a;
        if (a >= 64 && a < 80) return a - 48;
        return -1;
    endfunction

    task automatic m_reset();
        m_ac = 7'h00; m_disp = 0; m_cur = 0; m_blink = 0; m_inc = 1; m_two = 0;
        m_init = 0; m_err = 0; m_fs = 0; m_phase = 0;
        sb.delete();
    endtask

    task automatic model_write(input bit rs, input logic [7:0] d, input bit in_busy);
        exp_t e;
        int   idx;
        if (m_phase == 0 || in_busy) begin
            m_err = 1;
            return;
        end
        if (m_phase == 1 && rs) return;
        if (rs) begin
            idx = m_index(m_ac);
            if (idx >= 0) m_mem[idx] = d;
            m_ac = m_step(m_ac, m_inc);
        end else begin
            if (m_phase == 1) begin
                if (d[7:4] == 4'h3) begin
                    m_fs++;
                    if (m_fs == 3) begin m_phase = 2; m_init = 1; end
                end else m_fs = 0;
            end
            if (d >= 8'h80) m_ac = d[6:0];
            else if (d >= 8'h40) begin end
            else if (d >= 8'h20) m_two = d[3];
            else if (d >= 8'h10) begin if (!d[3]) m_ac = m_step(m_ac, d[2]); end
            else if (d >= 8'h08) begin m_disp = d[2] & LCD_ON; m_cur = d[1]; m_blink = d[0]; end
            else if (d >= 8'h04) m_inc = d[1];
            else if (d >= 8'h02) m_ac = 7'h00;
            else if (d == 8'h01) begin
                m_ac = 7'h00; m_inc = 1;
                for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            end
        end
        e.rs = rs; e.code = d; e.ac = m_ac; e.disp = m_disp; e.cur = m_cur;
        e.blink = m_blink; e.inc = m_inc; e.two = m_two; e.init = m_init;
        sb.push_back(e);
    endtask

    // Returns on the clock edge at which the falling strobe is applied.
    task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        LCD_DATA = d; LCD_RS = rs; LCD_RW = rw; LCD_EN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        LCD_EN = 1'b0;
        @(posedge clk);
    endtask

    function automatic int gap_for(input bit rs, input logic [7:0] d);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? BL + 40 : BC + 5;
    endfunction

    task automatic wr(input bit rs, input logic [7:0] d, input bit in_busy, input int gap);
        model_write(rs, d, in_busy);
        strobe(rs, 1'b0, d);
        repeat (gap) @(posedge clk);
    endtask

    task automatic wrg(input bit rs, input logic [7:0] d);
        wr(rs, d, 1'b0, gap_for(rs, d));
    endtask

    task automatic rd_chk(input int i);
        @(negedge clk);
        rd_addr = 5'(i);
        @(posedge clk);
        #1;
        check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(m_mem[i]));
    endtask

    // Monitor: every wr_valid pulse is matched against the oldest predicted write.
    initial forever begin
        @(posedge clk);
        #1;
        if (wr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_wr: got rs=%b code=%h, expected no write", wr_rs, wr_code);
            end else begin
                exp_t a, e;
                e = sb.pop_front();
                a = {wr_rs, wr_code, addr_cnt, disp_on, cursor_on, blink_on, entry_inc, two_line, init_ok};
                check($sformatf("wr%0d", n_wr), 32'(a), 32'(e));
                n_wr++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of run, expected finish before 5 ms");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         r;
        rst = 1'b0; LCD_EN = 1'b0; LCD_DATA = 8'h00; LCD_RS = 1'b0; LCD_RW = 1'b0;
        LCD_ON = 1'b1; rd_addr = 5'd0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ac", 32'(addr_cnt), 32'h0);
        check("rst_flags", 32'({disp_on, cursor_on, blink_on, entry_inc, two_line, init_ok}), 32'b000100);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_wr_valid", 32'(wr_valid), 32'h0);
        check("rst_err", 32'(err_timing), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        @(negedge clk) rst = 1'b1;

        // Write during the power-up wait.
        repeat (45) @(posedge clk);
        wr(0, 8'h30, 1'b0, 3);
        #1;
        check("pwr_err", 32'(err_timing), 32'(m_err));
        check("pwr_init", 32'(init_ok), 32'h0);

        // Reset mid-wait aborts back to reset values.
        @(negedge clk) rst = 1'b0;
        m_reset();
        @(negedge clk);
        check("rst2_err", 32'(err_timing), 32'h0);
        check("rst2_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        repeat (PC + 10) @(posedge clk);
        #1;
        check("pwr_done_busy", 32'(busy), 32'h0);
        m_phase = 1;

        // Function-set sequence; a data write before init is silently dropped.
        wrg(1, 8'h55);
        check("wait_fs_data_err", 32'(err_timing), 32'h0);
        wrg(0, 8'h30); wrg(0, 8'h30); wrg(0, 8'h30);
        check("init_ok", 32'(init_ok), 32'h1);
        wrg(0, 8'h3C);
        check("two_line", 32'(two_line), 32'h1);

        // Display control then clear with long busy.
        wrg(0, 8'h0E);
        model_write(0, 8'h01, 1'b0);
        strobe(0, 1'b0, 8'h01);
        repeat (BL - 3) @(posedge clk);
        #1;
        check("clear_busy_hi", 32'(busy), 32'h1);
        repeat (6) @(posedge clk);
        #1;
        check("clear_busy_lo", 32'(busy), 32'h0);
        for (int i = 0; i < 32; i++) rd_chk(i);
        check("clear_ac", 32'(addr_cnt), 32'h0);

        // Text on both lines; a read strobe in between has no effect.
        wrg(0, 8'h80); wrg(1, 8'h61); wrg(1, 8'h3D);
        rd_chk(0); rd_chk(1);
        strobe(0, 1'b1, 8'h01);
        repeat (BC + 5) @(posedge clk);
        wrg(0, 8'hC1); wrg(1, 8'h72);
        rd_chk(17);
        check("ac_line2", 32'(addr_cnt), 32'h42);

        // Line wrap in both directions.
        wrg(0, 8'hA7); wrg(1, 8'h41);
        check("wrap_inc", 32'(addr_cnt), 32'h40);
        wrg(0, 8'h04); wrg(1, 8'h42);
        check("wrap_dec", 32'(addr_cnt), 32'h27);
        rd_chk(16);

        // Randomized instruction/data mix, all well-timed.
        wrg(0, 8'h06);
        for (int k = 0; k < 200; k++) begin
            LCD_ON = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 99);
            if (r < 45) wrg(1, 8'($urandom_range(0, 255)));
            else if (r < 60) begin
                int p;
                p = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) + 40 * $urandom_range(0, 1)
                                                : $urandom_range(0, 79);
                d = (p < 40) ? 8'(8'h80 + p) : 8'(8'hC0 + p - 40);
                wrg(0, d);
            end
            else if (r < 67) wrg(0, 8'(8'h04 + $urandom_range(0, 3)));
            else if (r < 74) wrg(0, 8'(8'h08 + $urandom_range(0, 7)));
            else if (r < 81) wrg(0, 8'(8'h10 + $urandom_range(0, 15)));
            else if (r < 86) wrg(0, 8'(8'h20 + $urandom_range(0, 31)));
            else if (r < 90) wrg(0, 8'(8'h40 + $urandom_range(0, 63)));
            else if (r < 93) wrg(0, 8'(8'h02 + $urandom_range(0, 1)));
            else if (r < 95) wrg(0, 8'h01);
            else wrg(0, 8'h00);
            rd_chk($urandom_range(0, 31));
        end
        LCD_ON = 1'b1;
        check("rand_err", 32'(err_timing), 32'h0);

        // Second strobe ten cycles after a data write lands while busy.
        wrg(0, 8'h85);
        wr(1, 8'h4B, 1'b0, 7);
        wr(1, 8'h7A, 1'b1, 3);
        #1;
        check("busy_err", 32'(err_timing), 32'(m_err));
        check("busy_ac", 32'(addr_cnt), 32'(m_ac));
        rd_chk(5);
        rd_chk(6);

        repeat (BC + 10) @(posedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
